edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge/pulse event scheduler: monitors `N_CH` single-bit inputs, detects a per-channel configurable event (rising edge, falling edge or one-cycle 010 pulse), and queues one pending event per channel. A round-robin arbiter shares a single valid/ready event output between channels. Sits between raw status lines and the consumer that services them; overflow is flagged when an event arrives on a channel whose previous event is still queued.

## Interface
- `N_CH`, default 4: number of monitored channels, ≥ 2.
- `CH_W`, default `$clog2(N_CH)`: channel index width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `a`  in  N_CH  monitored lines, synchronous to `clk`.
- `mode`  in  2*N_CH  per-channel mode; channel i is bits [2i+1:2i]. 00 off, 01 rising, 10 falling, 11 pulse (010).
- `evt_valid`  out  1  event present on `evt_ch`.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ch`  out  CH_W  channel index of the presented event.
- `ovf`  out  N_CH  sticky per-channel overflow flags.
- `ovf_clr`  in  N_CH  per-bit synchronous clear of `ovf`.

## Operation
- History: per channel, `h1`/`h2` hold `a` delayed by 1 and 2 cycles. Both update every cycle regardless of mode.
- Detect in cycle t, combinational:
  - rising: `~h1 & a`
  - falling: `h1 & ~a`
  - pulse: `~h2 & h1 & ~a`
  - off: never.
- Pending: `pend[i]` is set at the clock edge after a detect on channel i.
- Overflow: a detect on channel i while `pend[i]=1` and channel i is not being granted that cycle sets `ovf[i]`.
  - The event is dropped; `pend[i]` stays 1.
- Same-cycle detect and grant on channel i: `pend[i]` stays 1 as a new event. No overflow.
- `ovf_clr[i]` clears `ovf[i]`. If clear and set coincide, set wins.
- Output FSM:
  - IDLE: `evt_valid=0`. If any `pend`, load the grant winner into `evt_ch`, clear its `pend` bit, go to PRESENT.
  - PRESENT: `evt_valid=1`. `evt_ch` is stable until the handshake.
  - On `evt_valid & evt_ready`:
    - if any `pend`, load the next winner the same cycle and stay in PRESENT (back-to-back, one event per cycle);
    - else go to IDLE.
- Round-robin: search starts at `last+1` and wraps modulo `N_CH`. `last` updates to the granted channel on each load.
- Mode change takes effect on the next detect evaluation. It does not clear `pend`, `ovf` or history.

## Timing
- Reset values:
  - `evt_valid=0`, `evt_ch=0`, `ovf=0`, `pend=0`;
  - `h1`/`h2` = 0;
  - `last=N_CH-1`, so channel 0 has first priority.
- `a` held high through reset release produces a rising event on the first cycle in mode 01.
- Latency: detect in cycle t → `pend` visible in t+1 → `evt_valid=1` in t+2 when IDLE.
- A 010 pulse with the 1 in cycle t is detected in cycle t+1, so `evt_valid` rises in t+3.
- `evt_valid` never drops without a handshake. `evt_ch` never changes while `evt_valid & ~evt_ready`.
- Reset asserted mid-operation clears all state immediately, asynchronously. Pending and in-flight events are lost.

## Structure
- Package `edge_evt_pkg`:
  - typedef enum logic [1:0] `edge_mode_t`: `MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_PULSE`;
  - FSM state typedef `evt_state_t` with values IDLE and PRESENT.
- Sub-module `edge_rr_arbiter`: combinational round-robin pick.
  - Inputs: request vector and `last`.
  - Outputs: one-hot grant, index, `any`.
- Top holds history, pending/overflow registers, FSM and output registers.

## Test plan
- Channel 0 in mode 01, `evt_ready=1`, `a[0]` goes 0→1 in cycle 5 → `evt_valid=1` and `evt_ch=0` in cycle 7 only, one cycle wide.
- Channel 1 in mode 11, `a[1]` = 0,1,0 (1 in cycle 10) → one event, `evt_ch=1`, in cycle 13. A 0,1,1,0 sequence → no event.
- All four channels in mode 01, `a` goes 0→F in one cycle, `evt_ready=1` → `evt_ch` = 0,1,2,3 on consecutive cycles. A second burst continues from 0 after `last=3`.
- `evt_ready=0`, channel 2 in mode 10 with two falling edges 4 cycles apart → first event held stable, `ovf[2]=1`. After `ovf_clr[2]` pulse → `ovf[2]=0`. `ovf_clr[2]` asserted in the same cycle as a new overflow → `ovf[2]` stays 1.
- Pending on channel 3 and channel 3 detects again in its grant cycle → two events delivered, `ovf[3]=0`.
- `rst` asserted while `evt_valid=1` with two channels pending → all outputs 0 immediately, no events after release until new detects.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event arbiter: per-channel detect modes, output FSM
// states and the single-channel detect function.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_PULSE = 2'b11
  } edge_mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } evt_state_t;

  // a is the current sample, h1/h2 the samples from one and two cycles earlier.
  function automatic logic detect(input edge_mode_t m, input logic a,
                                  input logic h1, input logic h2);
    logic hit;
    hit = 1'b0;
    case (m)
      MODE_RISE:  hit = ~h1 & a;
      MODE_FALL:  hit = h1 & ~a;
      MODE_PULSE: hit = ~h2 & h1 & ~a;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_rr_arbiter.sv
// Combinational round-robin pick: the first requester found searching upward
// from last+1, wrapping modulo N_CH.
module edge_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  assign any_o = |req_i;

  // Two descending scans: the lowest requester at or below last is the fallback,
  // the lowest requester above last overrides it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_i[i] && (i <= int'(last_i))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = CH_W'(i);
      end
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_i[i] && (i > int'(last_i))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge/pulse event detector with one pending slot per channel,
// sticky overflow flags and a round-robin valid/ready event output.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   a,
  input  logic [2*N_CH-1:0] mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  logic [N_CH-1:0] h1_q, h2_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  evt_state_t      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] last_q, last_d;

  logic [N_CH-1:0] det;
  logic [N_CH-1:0] gnt, take;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            load;

  always_comb begin
    det = '0;
    for (int i = 0; i < N_CH; i++) begin
      det[i] = detect(edge_mode_t'(mode[2*i +: 2]), a[i], h1_q[i], h2_q[i]);
    end
  end

  edge_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req_i  (pend_q),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // A new winner is loaded from IDLE, or on the handshake cycle when PRESENT.
  assign load = gnt_any && ((state_q == IDLE) || evt_ready);
  assign take = load ? gnt : '0;

  // A detect on the channel being granted re-arms its pending bit rather than overflowing.
  always_comb begin
    pend_d  = (pend_q & ~take) | det;
    ovf_d   = (ovf_q & ~ovf_clr) | (det & pend_q & ~take);
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (load) begin
      state_d = PRESENT;
      ch_d    = gnt_idx;
      last_d  = gnt_idx;
    end else if ((state_q == PRESENT) && evt_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: every register here is state, so all use non-blocking assignments and
  // all take the asynchronous reset; there is no memory array to leave unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q    <= '0;
      h2_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CH_W'(N_CH - 1);
    end else begin
      h1_q    <= a;
      h2_q    <= h1_q;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign evt_ch    = ch_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: stimulus pushes expected (channel, cycle)
// pairs into a scoreboard that a negedge monitor pops on every handshake.
module tb_edge_event_arbiter;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = '0;
  logic [7:0] mode = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic [3:0] ovf;
  logic [3:0] ovf_clr = '0;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Inputs set after step() belong to the cycle numbered by the current cyc.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: pops on each handshake, and checks that a stalled event stays put.
  initial begin
    logic hold;
    int   hold_ch;
    exp_t e;
    hold    = 1'b0;
    hold_ch = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", int'(evt_valid), 1);
          check("stall_ch", int'(evt_ch), hold_ch);
        end
        if (evt_valid && evt_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_evt", int'(evt_ch), -1);
          end else begin
            e = sb.pop_front();
            check("evt_ch", int'(evt_ch), e.ch);
            check("evt_cycle", cyc, e.cyc);
          end
        end
        hold    = evt_valid && !evt_ready;
        hold_ch = int'(evt_ch);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2 rst = 1'b1;
    #2;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_ch", int'(evt_ch), 0);
    check("rst_ovf", int'(ovf), 0);
    step(3);
    rst = 1'b0;

    // Channel 0 rising: event two cycles after the edge, exactly once.
    evt_ready = 1'b1;
    mode = 8'h01;
    step(3);
    a = 4'h1; t = cyc;
    expect_evt(0, t + 2);
    step(5);
    a = 4'h0;
    step(4);

    // Channel 1 pulse: 010 fires three cycles after the 1; 0110 never fires.
    mode = 8'h0C;
    step(3);
    a = 4'h2; t = cyc;
    expect_evt(1, t + 3);
    step(1);
    a = 4'h0;
    step(6);
    a = 4'h2;
    step(2);
    a = 4'h0;
    step(6);

    // Fresh reset so last=3, then bursts across all channels.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    mode = 8'h55;
    step(2);
    a = 4'hF; t = cyc;
    for (int k = 0; k < 4; k++) expect_evt(k, t + 2 + k);
    step(8);
    a = 4'h0;
    step(3);
    a = 4'hF; t = cyc;
    for (int k = 0; k < 4; k++) expect_evt(k, t + 2 + k);
    step(8);
    a = 4'h0;
    step(3);
    a = 4'h5; t = cyc;               // last=3: order 0 then 2
    expect_evt(0, t + 2);
    expect_evt(2, t + 3);
    step(6);
    a = 4'h0;
    step(3);
    a = 4'h9; t = cyc;               // last=2: order 3 then 0
    expect_evt(3, t + 2);
    expect_evt(0, t + 3);
    step(6);
    a = 4'h0;
    step(3);

    // Channel 2 falling with the consumer stalled: presented, pending, then overflow.
    evt_ready = 1'b0;
    mode = 8'h20;
    a = 4'h4;
    step(3);
    a = 4'h0;                        // first fall: presented
    step(2);
    a = 4'h4;
    step(2);
    a = 4'h0;                        // second fall: pending
    step(2);
    a = 4'h4;
    step(2);
    a = 4'h0;                        // third fall: overflow
    step(1);
    check("ovf2_set", int'(ovf), 4);
    ovf_clr = 4'h4;
    step(1);
    ovf_clr = 4'h0;
    check("ovf2_cleared", int'(ovf), 0);
    a = 4'h4;
    step(2);
    a = 4'h0;                        // fall while pending, clear in the same cycle
    ovf_clr = 4'h4;
    step(1);
    ovf_clr = 4'h0;
    check("ovf2_set_wins", int'(ovf), 4);
    ovf_clr = 4'h4;
    step(1);
    ovf_clr = 4'h0;
    check("ovf2_recleared", int'(ovf), 0);
    evt_ready = 1'b1; t = cyc;
    expect_evt(2, t);
    expect_evt(2, t + 1);
    step(4);

    // Channel 3 re-detects in its own grant cycle: two events, no overflow.
    evt_ready = 1'b0;
    mode = 8'h41;
    a = 4'h0;
    step(2);
    a = 4'h1;                        // ch0 presented and stalled
    step(3);
    a = 4'h9;                        // ch3 pending
    step(2);
    a = 4'h1;
    step(2);
    a = 4'h9; evt_ready = 1'b1; t = cyc;
    expect_evt(0, t);
    expect_evt(3, t + 1);
    expect_evt(3, t + 2);
    step(1);
    check("ovf3_clear", int'(ovf), 0);
    step(4);

    // Reset mid-transfer with ch1 presented and ch2/ch3 pending: everything is lost.
    evt_ready = 1'b0;
    mode = 8'h55;
    a = 4'h0;
    step(3);
    a = 4'hE;                        // last=3: ch1 presented, 2 and 3 pending
    step(3);
    check("pre_rst_valid", int'(evt_valid), 1);
    check("pre_rst_ch", int'(evt_ch), 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_ch", int'(evt_ch), 0);
    check("async_rst_ovf", int'(ovf), 0);
    a = 4'h0;
    step(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    step(10);
    a = 4'h2; t = cyc;
    expect_evt(1, t + 2);
    step(6);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
